// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE-style adder/subtractor with round-to-nearest-even and subnormal support.
// Define FP_ADDSUB_SPECIAL_EN for NaN/Inf handling; without it, all-ones exponents are finite and overflow saturates.
module fp_addsub_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] s,
    output logic                  inexact,
    output logic                  overflow
);
    localparam int W = 1 + EXP_W + FRAC_W;
    localparam int X = FRAC_W + 4;
    localparam logic [15:0] SH_MAX = 16'(FRAC_W + 3);
    localparam logic [EXP_W:0] E_ONES = {1'b0, {EXP_W{1'b1}}};
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};
`ifdef FP_ADDSUB_SPECIAL_EN
    localparam logic [W-2:0] OVF_MAG = INF_MAG;
`else
    localparam logic [W-2:0] OVF_MAG = {{(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
`endif

    assign in_ready = !(out_valid && !out_ready);

    logic             sa, sb, a_big;
    logic [EXP_W-1:0] ea, eb, el, es;
    logic [FRAC_W:0]  ma, mb, ml, ms;
    logic [15:0]      dsh;
    logic [X-1:0]     ms_x, ms_al;
    logic [2:0]       sp_d;

    always_comb begin
        sa    = a[W-1];
        sb    = b[W-1] ^ sub;
        ea    = (a[W-2:FRAC_W] == '0) ? EXP_W'(1) : a[W-2:FRAC_W];
        eb    = (b[W-2:FRAC_W] == '0) ? EXP_W'(1) : b[W-2:FRAC_W];
        ma    = {|a[W-2:FRAC_W], a[FRAC_W-1:0]};
        mb    = {|b[W-2:FRAC_W], b[FRAC_W-1:0]};
        a_big = {ea, ma} >= {eb, mb};
        el    = a_big ? ea : eb;
        es    = a_big ? eb : ea;
        ml    = a_big ? ma : mb;
        ms    = a_big ? mb : ma;
        dsh   = (16'(el) - 16'(es) > SH_MAX) ? SH_MAX : 16'(el) - 16'(es);
        ms_x  = {ms, 3'b000};
        // everything shifted past the sticky position collapses into it
        ms_al = (ms_x >> dsh) | X'(|(ms_x & ~({X{1'b1}} << dsh)));
    end

`ifdef FP_ADDSUB_SPECIAL_EN
    logic a_inf, b_inf, a_nan, b_nan;
    always_comb begin
        a_inf = &a[W-2:FRAC_W] && a[FRAC_W-1:0] == '0;
        b_inf = &b[W-2:FRAC_W] && b[FRAC_W-1:0] == '0;
        a_nan = &a[W-2:FRAC_W] && a[FRAC_W-1:0] != '0;
        b_nan = &b[W-2:FRAC_W] && b[FRAC_W-1:0] != '0;
        sp_d  = {a_nan || b_nan || (a_inf && b_inf && sa != sb), a_inf || b_inf, a_inf ? sa : sb};
    end
`else
    assign sp_d = 3'b000;
`endif

    logic             v1_q, sg1_q, sub1_q;
    logic [EXP_W-1:0] e1_q;
    logic [FRAC_W:0]  ml1_q;
    logic [X-1:0]     ms1_q;
    logic [2:0]       sp1_q;

    logic [X:0]       sum;
    logic [15:0]      lz, lim, nsh;
    logic [X-1:0]     n2_d;
    logic [EXP_W:0]   e2_d;
    logic             sg2_d;

    always_comb begin
        sum = sub1_q ? {1'b0, ml1_q, 3'b000} - {1'b0, ms1_q} : {1'b0, ml1_q, 3'b000} + {1'b0, ms1_q};
        lz  = SH_MAX;
        for (int i = 0; i < X; i++)
            if (sum[i]) lz = SH_MAX - 16'(i);
        // never normalise below the minimum exponent: that is where subnormals come from
        lim   = 16'(e1_q) - 16'd1;
        nsh   = (lz < lim) ? lz : lim;
        n2_d  = sum[X] ? {sum[X:2], |sum[1:0]} : sum[X-1:0] << nsh;
        e2_d  = sum[X] ? {1'b0, e1_q} + 1'b1 : {1'b0, e1_q} - (EXP_W+1)'(nsh);
        sg2_d = sg1_q && !(sub1_q && sum == '0);
    end

    logic             v2_q, sg2_q;
    logic [EXP_W:0]   e2_q;
    logic [X-1:0]     n2_q;
    logic [2:0]       sp2_q;

    logic [FRAC_W:0]   mant, mf;
    logic [FRAC_W+1:0] mr;
    logic [EXP_W:0]    ef;
    logic              g, rs, ovf, inx_d, ovf_d;
    logic [W-1:0]      s_d;

    always_comb begin
        mant  = n2_q[X-1:3];
        g     = n2_q[2];
        rs    = |n2_q[1:0];
        mr    = {1'b0, mant} + (FRAC_W+2)'(g && (rs || mant[0]));
        mf    = mr[FRAC_W+1] ? mr[FRAC_W+1:1] : mr[FRAC_W:0];
        ef    = e2_q + (EXP_W+1)'(mr[FRAC_W+1]);
        ovf   = ef >= E_ONES;
        s_d   = sp2_q[2] ? QNAN :
                sp2_q[1] ? {sp2_q[0], INF_MAG} :
                ovf      ? {sg2_q, OVF_MAG} :
                {sg2_q, mf[FRAC_W] ? ef[EXP_W-1:0] : {EXP_W{1'b0}}, mf[FRAC_W-1:0]};
        inx_d = !(sp2_q[2] || sp2_q[1]) && (g || rs || ovf);
        ovf_d = !(sp2_q[2] || sp2_q[1]) && ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            out_valid <= 1'b0;
            s         <= '0;
            inexact   <= 1'b0;
            overflow  <= 1'b0;
        end else if (in_ready) begin
            v1_q      <= in_valid;
            v2_q      <= v1_q;
            out_valid <= v2_q;
            if (v2_q) begin
                s        <= s_d;
                inexact  <= inx_d;
                overflow <= ovf_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready) begin
            sg1_q  <= a_big ? sa : sb;
            sub1_q <= sa ^ sb;
            e1_q   <= el;
            ml1_q  <= ml;
            ms1_q  <= ms_al;
            sp1_q  <= sp_d;
            sg2_q  <= sg2_d;
            e2_q   <= e2_d;
            n2_q   <= n2_d;
            sp2_q  <= sp1_q;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed and randomized checks of fp_addsub_pipe (binary32) against an exact-arithmetic model.
// Honours FP_ADDSUB_SPECIAL_EN the same way the design does.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready, inexact, overflow;
    logic [31:0] a, b, s;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    typedef struct packed {logic [31:0] s; logic inx; logic ovf;} res_t;
    res_t        exp_q[$];
    res_t        r;
    logic [31:0] m_s;
    logic        m_i, m_o, stall_q = 1'b0;
    logic [33:0] hold_q;

    fp_addsub_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .inexact(inexact), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [63:0] obs, input logic [63:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Exact value: the fraction integer scaled by 2^(e-1) in units of the smallest subnormal.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic sb,
                                  output logic [31:0] rs, output logic inx, output logic ovf);
        logic [299:0] vx, vy, v, mant, rem, half;
        logic         sx, sy, sr;
        int           ex, ey, p, k, e;
        sx = x[31]; sy = y[31] ^ sb;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        inx = 1'b0; ovf = 1'b0;
`ifdef FP_ADDSUB_SPECIAL_EN
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
            (ex == 255 && ey == 255 && sx != sy)) begin rs = 32'h7FC00000; return; end
        if (ex == 255) begin rs = {sx, 8'hFF, 23'h0}; return; end
        if (ey == 255) begin rs = {sy, 8'hFF, 23'h0}; return; end
`endif
        vx = 300'({ex != 0, x[22:0]}) << (ex == 0 ? 0 : ex - 1);
        vy = 300'({ey != 0, y[22:0]}) << (ey == 0 ? 0 : ey - 1);
        if (sx == sy) begin v = vx + vy; sr = sx; end
        else if (vx > vy) begin v = vx - vy; sr = sx; end
        else if (vy > vx) begin v = vy - vx; sr = sy; end
        else begin v = '0; sr = 1'b0; end
        p = -1;
        for (int i = 0; i < 300; i++) if (v[i]) p = i;
        if (p <= 23) begin
            rs = {sr, 7'b0, v[23], v[22:0]};
            return;
        end
        k    = p - 23;
        mant = v >> k;
        rem  = v & ((300'd1 << k) - 300'd1);
        half = 300'd1 << (k - 1);
        if (rem > half || (rem == half && mant[0])) mant = mant + 300'd1;
        if (mant[24]) begin mant = mant >> 1; k++; end
        e   = k + 1;
        inx = rem != 0;
        if (e >= 255) begin
            ovf = 1'b1; inx = 1'b1;
`ifdef FP_ADDSUB_SPECIAL_EN
            rs = {sr, 8'hFF, 23'h0};
`else
            rs = {sr, 8'hFE, 23'h7FFFFF};
`endif
        end else rs = {sr, 8'(e), mant[22:0]};
    endfunction

    task automatic gen_op(output logic [31:0] x, output logic [31:0] y, output logic sb);
        int unsigned sel = $urandom_range(0, 3);
        x = $urandom; y = $urandom; sb = 1'($urandom_range(0, 1));
        case (sel)
            1: y[30:23] = x[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
            2: begin x[30:23] = 8'($urandom_range(0, 1)); y[30:23] = 8'($urandom_range(0, 2)); end
            3: begin y = x; sb = 1'b1; end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                model(a, b, sub, m_s, m_i, m_o);
                exp_q.push_back('{m_s, m_i, m_o});
            end
            if (stall_q) chk({out_valid, s, inexact, overflow}, {1'b1, hold_q}, "hold_while_stalled");
            chk(in_ready, !(out_valid && !out_ready), "in_ready");
            if (out_valid && out_ready) begin
                n_out++;
                chk(exp_q.size() != 0, 1, "unexpected_result");
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    chk({s, inexact, overflow}, {r.s, r.inx, r.ovf}, "result_vs_model");
                end
            end
        end
        stall_q = rst_n && out_valid && !out_ready;
        hold_q  = {s, inexact, overflow};
    end

    task automatic directed(input logic [31:0] x, input logic [31:0] y, input logic sb,
                            input logic [31:0] es, input logic ei, input logic eo, input string tag);
        in_valid = 1'b1; a = x; b = y; sub = sb; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk(out_valid, i == 3, {tag, "_latency"});
        end
        chk(s, es, {tag, "_s"});
        chk(inexact, ei, {tag, "_inexact"});
        chk(overflow, eo, {tag, "_overflow"});
        @(posedge clk); #1;
    endtask

    logic [31:0] op_a[5], op_b[5];
    logic        op_s[5];
    int          k, n0;

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk(out_valid, 0, "reset_out_valid");
        chk({s, inexact, overflow}, 0, "reset_outputs");
        chk(in_ready, 1, "reset_in_ready");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        directed(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, "one_plus_two");
        directed(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, "cancel");
        directed(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, "subnormal_add");
        directed(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b1, 1'b0, "tie_even");
        directed(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b1, 1'b0, "round_up");
        directed(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 1'b0, 1'b0, "normal_to_subnormal");
        directed(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0, "neg_larger");
`ifdef FP_ADDSUB_SPECIAL_EN
        directed(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, "inf_minus_inf");
        directed(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b1, "overflow_inf");
`else
        directed(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 1'b1, 1'b1, "overflow_saturate");
`endif

        for (int i = 0; i < 5; i++) gen_op(op_a[i], op_b[i], op_s[i]);
        n0 = n_out; k = 0;
        for (int c = 1; c <= 16; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            in_valid  = k < 5;
            a = k < 5 ? op_a[k] : '0; b = k < 5 ? op_b[k] : '0; sub = k < 5 ? op_s[k] : 1'b0;
            @(negedge clk);
            if (c >= 4 && c <= 6) chk(in_ready, 0, "stall_in_ready_low");
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk(k, 5, "stall_accepted");
        chk(n_out - n0, 5, "stall_delivered");

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; gen_op(a, b, sub);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk(out_valid, 1, "inflight_head_valid");
        #2 rst_n = 1'b0;
        #1;
        chk(out_valid, 0, "midop_reset_out_valid");
        chk(in_ready, 1, "midop_reset_in_ready");
        exp_q.delete();
        n0 = n_out;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk(n_out - n0, 1, "post_reset_results");

        for (int c = 0; c < 600; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            gen_op(a, b, sub);
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        chk(exp_q.size(), 0, "drain_outstanding");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
